// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared state encoding and opcode constants for the sequencing control unit
// Optional feature macro: CU_MULDIV_EN (adds the MULDIV state).
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_EXEC     = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_WB       = 3'd3,
        ST_INTRPT   = 3'd4
`ifdef CU_MULDIV_EN
        ,
        ST_MULDIV   = 3'd5
`endif
    } cu_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/cu_irq_arb.sv
// rtl/cu_irq_arb.sv - interrupt edge capture, pending storage and lowest-index priority select
// Ports: clk, rst_n (async, active-low); irq/irq_en_mask/mie request inputs;
//        clr removes the selected source; irq_req says an interrupt must be taken
//        at the next completion; cause is the lowest enabled pending index.
module cu_irq_arb #(
    parameter int NUM_IRQ = 4,
    parameter int CAUSE_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_en_mask,
    input  logic               mie,
    input  logic               clr,
    output logic               irq_req,
    output logic [CAUSE_W-1:0] cause
);

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] clr_oh;

    assign rise = irq & ~irq_q;
    assign elig = pending & irq_en_mask;

    // An edge arriving in the completing cycle is already counted so the
    // instruction retiring in that cycle diverts to the handler.
    assign irq_req = mie & (|((pending | rise) & irq_en_mask));

    always_comb begin
        cause = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) cause = CAUSE_W'(i);
        end
    end

    always_comb begin
        clr_oh = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_oh[i] = clr && (|elig) && (cause == CAUSE_W'(i));
        end
    end

    // Clear first, then OR the new edges so a coincident edge survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            irq_q   <= irq;
            pending <= (pending & ~clr_oh) | rise;
        end
    end

endmodule

// File: rtl/cu_seq_ctrl.sv
// rtl/cu_seq_ctrl.sv - multi-cycle instruction sequencing FSM with interrupt entry
// Optional feature macro: CU_MULDIV_EN (R-type with funct7_b0=1 runs through MULDIV).
// Ports: clk, rst_n (async, active-low); opcode/func/funct7_b0 instruction fields;
//        irq/irq_en_mask/mie interrupt inputs; mem_ready, muldiv_done handshakes;
//        pc_write, rfile_write, mem_rden1, mem_rden2, mem_we2, csr_we, intrpt_taken,
//        mret_exec, muldiv_start strobes; irq_cause serviced index; state debug view.
module cu_seq_ctrl
    import cu_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int CAUSE_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic [2:0]         func,
    input  logic               funct7_b0,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_en_mask,
    input  logic               mie,
    input  logic               mem_ready,
    input  logic               muldiv_done,
    output logic               pc_write,
    output logic               rfile_write,
    output logic               mem_rden1,
    output logic               mem_rden2,
    output logic               mem_we2,
    output logic               csr_we,
    output logic               intrpt_taken,
    output logic               mret_exec,
    output logic               muldiv_start,
    output logic [CAUSE_W-1:0] irq_cause,
    output logic [2:0]         state
);

    cu_state_e          state_q;
    cu_state_e          state_d;
    logic               complete;
    logic               irq_req;
    logic [CAUSE_W-1:0] cause;
    logic               unused_ok;

`ifdef CU_MULDIV_EN
    assign unused_ok = ^func[2:1];
`else
    assign unused_ok = ^{func[2:1], funct7_b0, muldiv_done};
`endif

    cu_irq_arb #(
        .NUM_IRQ (NUM_IRQ),
        .CAUSE_W (CAUSE_W)
    ) u_irq_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq         (irq),
        .irq_en_mask (irq_en_mask),
        .mie         (mie),
        .clr         (intrpt_taken),
        .irq_req     (irq_req),
        .cause       (cause)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    assign state     = state_q;
    assign irq_cause = (state_q == ST_INTRPT) ? cause : '0;

    always_comb begin
        state_d      = state_q;
        complete     = 1'b0;
        pc_write     = 1'b0;
        rfile_write  = 1'b0;
        mem_rden1    = 1'b0;
        mem_rden2    = 1'b0;
        mem_we2      = 1'b0;
        csr_we       = 1'b0;
        intrpt_taken = 1'b0;
        mret_exec    = 1'b0;
        muldiv_start = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_rden1 = 1'b1;
                if (mem_ready) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode)
                    OPC_LOAD: begin
                        mem_rden2 = 1'b1;
                        state_d   = ST_MEM_WAIT;
                    end
                    OPC_STORE: begin
                        mem_we2 = 1'b1;
                        state_d = ST_MEM_WAIT;
                    end
                    OPC_OP: begin
`ifdef CU_MULDIV_EN
                        if (funct7_b0) begin
                            muldiv_start = 1'b1;
                            state_d      = ST_MULDIV;
                        end else begin
                            pc_write    = 1'b1;
                            rfile_write = 1'b1;
                            complete    = 1'b1;
                        end
`else
                        pc_write    = 1'b1;
                        rfile_write = 1'b1;
                        complete    = 1'b1;
`endif
                    end
                    OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                        pc_write    = 1'b1;
                        rfile_write = 1'b1;
                        complete    = 1'b1;
                    end
                    OPC_SYSTEM: begin
                        pc_write = 1'b1;
                        complete = 1'b1;
                        if (func[0]) begin
                            rfile_write = 1'b1;
                            csr_we      = 1'b1;
                        end else begin
                            mret_exec = 1'b1;
                        end
                    end
                    default: begin
                        // branches and unknown opcodes only advance the PC
                        pc_write = 1'b1;
                        complete = 1'b1;
                    end
                endcase
            end
            ST_MEM_WAIT: begin
                if (opcode == OPC_STORE) begin
                    mem_we2 = 1'b1;
                    if (mem_ready) begin
                        pc_write = 1'b1;
                        complete = 1'b1;
                    end
                end else begin
                    mem_rden2 = 1'b1;
                    if (mem_ready) state_d = ST_WB;
                end
            end
            ST_WB: begin
                pc_write    = 1'b1;
                rfile_write = 1'b1;
                complete    = 1'b1;
            end
            ST_INTRPT: begin
                intrpt_taken = 1'b1;
                pc_write     = 1'b1;
                state_d      = ST_FETCH;
            end
`ifdef CU_MULDIV_EN
            ST_MULDIV: begin
                if (muldiv_done) begin
                    pc_write    = 1'b1;
                    rfile_write = 1'b1;
                    complete    = 1'b1;
                end
            end
`endif
            default: state_d = ST_FETCH;
        endcase

        if (complete) state_d = irq_req ? ST_INTRPT : ST_FETCH;
    end

endmodule

// File: doc/cu_seq_ctrl.md
CU_SEQ_CTRL -- requirements
Module: cu_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, meaning the number of interrupt sources (legal range 1..8).
REQ-002 SHALL have parameter CAUSE_W, default max(1,$clog2(NUM_IRQ)), meaning the width of irq_cause.
REQ-003 SHALL have port clk  in  1  meaning the system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  meaning the reset; reset is asynchronous and active-low.
REQ-005 SHALL have port opcode  in  7, port func  in  3 and port funct7_b0  in  1, carrying instruction bits [6:0], [14:12] and [25].
REQ-006 SHALL have port irq  in  NUM_IRQ (raw requests), port irq_en_mask  in  NUM_IRQ (per-source enable) and port mie  in  1 (global enable).
REQ-007 SHALL have port mem_ready  in  1 (memory access complete) and port muldiv_done  in  1 (multi-cycle unit finished).
REQ-008 SHALL have 1-bit outputs pc_write, rfile_write, mem_rden1 (fetch), mem_rden2 (data read), mem_we2 (data write), csr_we, intrpt_taken, mret_exec and muldiv_start.
REQ-009 SHALL have port irq_cause  out  CAUSE_W (index of the serviced source) and port state  out  3 (current FSM state, for debug).

Function
REQ-010 SHALL implement the states FETCH, EXEC, MEM_WAIT, WB, INTRPT and MULDIV, encoded 0 to 5.
REQ-011 In FETCH SHALL assert mem_rden1; it SHALL move to EXEC on mem_ready=1 and otherwise stay in FETCH.
REQ-012 In EXEC with a load (0000011) SHALL assert mem_rden2 and go to MEM_WAIT; with a store (0100011) it SHALL assert mem_we2 and go to MEM_WAIT.
REQ-013 In EXEC with R/I-ALU, LUI, AUIPC, JAL or JALR SHALL assert pc_write and rfile_write for one cycle; with a branch it SHALL assert pc_write only.
REQ-014 In EXEC with SYSTEM opcode (1110011) and func[0]=1 (csrrw) SHALL assert pc_write, rfile_write and csr_we; with func[0]=0 (mret) it SHALL assert pc_write and mret_exec.
REQ-015 In EXEC with an illegal or unused opcode SHALL assert pc_write only (NOP).
REQ-016 In MEM_WAIT SHALL hold mem_rden2/mem_we2 until mem_ready=1; a load then goes to WB, and a store asserts pc_write and exits.
REQ-017 In WB SHALL assert rfile_write and pc_write for exactly one cycle.
REQ-018 Every instruction-completing cycle (the pc_write cycle outside INTRPT) SHALL exit to INTRPT if mie and any bit of (pending & irq_en_mask) is set, and otherwise to FETCH.
REQ-019 Pending bit i SHALL set on a rising edge of irq[i]; masked pending bits SHALL be retained.
REQ-020 The selected cause SHALL be the lowest-indexed eligible bit, driven on irq_cause in INTRPT, and 0 elsewhere.
REQ-021 In INTRPT SHALL assert intrpt_taken and pc_write for one cycle, clear the pending bit of irq_cause, and go to FETCH.
REQ-022 When an edge arrives on the same cycle its bit is cleared, the set SHALL win.
REQ-023 Every output SHALL be decoded from state plus the instruction fields; outputs not listed for a state SHALL be 0.

Reset
REQ-024 rst_n=0 SHALL immediately force FETCH, clear all pending bits and the irq edge register, and drive every output except mem_rden1 to 0 (mem_rden1=1, state=0).
REQ-025 Reset mid-operation (in MEM_WAIT or MULDIV) SHALL abandon the access without asserting pc_write or rfile_write.

Configuration
REQ-026 With CU_MULDIV_EN defined, an R-type instruction with funct7_b0=1 in EXEC SHALL pulse muldiv_start and go to MULDIV.
REQ-027 MULDIV SHALL hold until muldiv_done=1, then assert pc_write and rfile_write and exit per REQ-018.
REQ-028 Without CU_MULDIV_EN, muldiv_start SHALL be tied 0, the MULDIV state SHALL not exist, and funct7_b0 SHALL be ignored (treated as a normal R-type).

Structure
REQ-029 Package cu_pkg SHALL hold the state enum and the opcode constants (the shared opcode defines).
REQ-030 Pending-bit storage, edge detection and the priority encoder SHALL live in one sub-module, cu_irq_arb.

Verification
REQ-031 add (0110011), mem_ready high on cycle 1 -> FETCH, EXEC; pc_write=rfile_write=1 in EXEC; back to FETCH at 2 cycles/instruction.
REQ-032 lw with mem_ready low for 3 cycles in MEM_WAIT -> mem_rden2 held for 4 cycles, then WB with rfile_write=1 for exactly one cycle.
REQ-033 NUM_IRQ=4, irq=4'b1010 edges during EXEC of an add, mask=4'hF, mie=1 -> INTRPT with irq_cause=1; next instruction -> INTRPT with irq_cause=3.
REQ-034 irq[2] edge with irq_en_mask[2]=0 -> no INTRPT and the bit stays pending; enabling mask[2] -> INTRPT with irq_cause=2 after the next completed instruction.
REQ-035 CU_MULDIV_EN, mul (funct7_b0=1), muldiv_done after 5 cycles -> one muldiv_start pulse, 5 cycles in MULDIV, then pc_write=rfile_write=1.
REQ-036 rst_n low during MEM_WAIT of sw -> state=0, pending=0 and mem_we2=0 at once; no pc_write.
